sdam_tx: RTL

Serial transmitter for the single-wire SDAM address/data link. It accepts an 8-bit address and 16-bit data word through a valid/ready handshake and serializes them onto `sda`, clocked by `scl`. Each frame consists of a start bit, a pad bit, the address LSB first, the data LSB first, and a stop bit. It is the sending end that drives the existing SDAM receiver, so that a loopback produces `aout`/`dout` with `avalid`/`dvalid`.

---
 rtl/sdam_tx.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sdam_tx.sv
// SDAM serial transmitter: start, pad, 8 address bits and 16 data bits
// (LSB first), then a stop bit, with optional idle gap bits after stop.
module sdam_tx #(
    parameter int GAP_BITS = 0
) (
    input  logic        scl,
    input  logic        reset_n,
    input  logic        tx_valid,
    input  logic [7:0]  tx_addr,
    input  logic [15:0] tx_data,
    output logic        tx_ready,
    output logic        tx_done,
    output logic        busy,
    output logic        sda
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_DATA,
        S_STOP,
        S_GAP
    } state_t;

    // Ready rises after stop + GAP_BITS bits; the GAP state covers all but
    // the last of them, which is already spent in IDLE.
    localparam int          GL       = (GAP_BITS >= 2) ? GAP_BITS - 2 : 0;
    localparam logic [3:0]  GAP_LAST = GL[3:0];

    state_t      state_q, state_d;
    logic [23:0] sh_q, sh_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [3:0]  gcnt_q, gcnt_d;
    logic        pad_q, pad_d;
    logic        sda_q, sda_d;
    logic        rdy_q, rdy_d;
    logic        done_q, done_d;
    logic        accept;

    assign accept = tx_valid & rdy_q;

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        pad_d   = pad_q;
        sda_d   = sda_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                sda_d = 1'b1;
                cnt_d = 5'd0;
            end
            S_START: begin
                cnt_d = 5'd0;
                if (!pad_q) begin
                    pad_d = 1'b1;
                    sda_d = 1'b0;
                end else begin
                    pad_d   = 1'b0;
                    state_d = S_ADDR;
                    sda_d   = sh_q[0];
                    sh_d    = sh_q >> 1;
                end
            end
            S_ADDR: begin
                sda_d = sh_q[0];
                sh_d  = sh_q >> 1;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd7) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == 5'd23) begin
                    state_d = S_STOP;
                    sda_d   = 1'b1;
                    cnt_d   = 5'd0;
                end else begin
                    sda_d = sh_q[0];
                    sh_d  = sh_q >> 1;
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_STOP: begin
                sda_d  = 1'b1;
                cnt_d  = 5'd0;
                done_d = 1'b1;
                if (GAP_BITS <= 1) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_GAP;
                    gcnt_d  = 4'd0;
                end
            end
            S_GAP: begin
                sda_d = 1'b1;
                cnt_d = 5'd0;
                if (gcnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gcnt_d = gcnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                sda_d   = 1'b1;
                cnt_d   = 5'd0;
            end
        endcase

        // A new frame may start from IDLE, or straight out of STOP when
        // there is no gap (ready is already high during the stop bit).
        if (accept) begin
            state_d = S_START;
            sda_d   = 1'b0;
            pad_d   = 1'b0;
            cnt_d   = 5'd0;
            sh_d    = {tx_data, tx_addr};
        end

        rdy_d = (state_d == S_IDLE) ||
                ((state_d == S_STOP) && (GAP_BITS == 0));
    end

    always_ff @(posedge scl) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            sh_q    <= 24'd0;
            cnt_q   <= 5'd0;
            gcnt_q  <= 4'd0;
            pad_q   <= 1'b0;
            sda_q   <= 1'b1;
            rdy_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            pad_q   <= pad_d;
            sda_q   <= sda_d;
            rdy_q   <= rdy_d;
            done_q  <= done_d;
        end
    end

    assign sda      = sda_q;
    assign tx_ready = rdy_q;
    assign busy     = ~rdy_q;
    assign tx_done  = done_q;

endmodule
